// File: rtl/cnn_pkg.sv
// Shared CNN datapath types and constants.
// Used by the DOM writer and its result FIFO.
package cnn_pkg;

  localparam int DOM_ADDR_W = 10;
  localparam int DATA_W     = 16;
  localparam int NUM_LAYERS = 4;

  localparam int DEF_LAYER0_BASE = 0;
  localparam int DEF_LAYER1_BASE = 64;
  localparam int DEF_LAYER2_BASE = 128;
  localparam int DEF_LAYER3_BASE = 192;

  typedef logic [1:0] layer_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } dom_wr_state_t;

  typedef struct packed {
    layer_t              layer;
    logic                last;
    logic [DATA_W-1:0]   data;
  } res_t;

  localparam int RES_W = $bits(res_t);

  function automatic logic [DATA_W-1:0] relu(
    input logic [DATA_W-1:0] d
  );
    return d[DATA_W-1] ? '0 : d;
  endfunction

endpackage

// File: rtl/dom_fifo.sv
// Synchronous result FIFO with flush.
// DEPTH must be a power of two (>=2).
module dom_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 19
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] wr_d;
  logic [AW-1:0] rd_q;
  logic [AW-1:0] rd_d;
  logic [AW:0]   cnt_q;
  logic [AW:0]   cnt_d;
  logic          push_ok;
  logic          pop_ok;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign rdata_o = mem_q[rd_q];
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_ok) wr_d = wr_q + AW'(1);
      if (pop_ok)  rd_d = rd_q + AW'(1);
      cnt_d = cnt_q + (AW+1)'(push_ok)
                    - (AW+1)'(pop_ok);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset; pointers define validity.
  always_ff @(posedge clk_i) begin
    if (push_ok && !flush_i) begin
      mem_q[wr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/dom_writer.sv
// CNN output stage: buffers MAC results and writes them to the DOM.
// Optional DOM_WRITER_RELU_EN clamps negative results to zero.
module dom_writer
  import cnn_pkg::*;
#(
  parameter int FIFO_DEPTH      = 4,
  parameter int WORDS_PER_LAYER = 64,
  parameter int LAYER0_BASE     = DEF_LAYER0_BASE,
  parameter int LAYER1_BASE     = DEF_LAYER1_BASE,
  parameter int LAYER2_BASE     = DEF_LAYER2_BASE,
  parameter int LAYER3_BASE     = DEF_LAYER3_BASE
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_data,
  input  logic [1:0]            in_layer,
  input  logic                  in_last,
  input  logic                  dom_grant,
  output logic [DOM_ADDR_W-1:0] dom_address,
  output logic [DATA_W-1:0]     dom_data,
  output logic                  dom_enable,
  output logic                  done,
  output logic                  overflow
);

  localparam logic [DOM_ADDR_W-1:0] OFF_MAX =
    DOM_ADDR_W'(WORDS_PER_LAYER - 1);

  dom_wr_state_t         state_q;
  dom_wr_state_t         state_d;
  logic [DOM_ADDR_W-1:0] off_q [NUM_LAYERS];
  logic [DOM_ADDR_W-1:0] off_d [NUM_LAYERS];
  logic [DOM_ADDR_W-1:0] addr_q;
  logic [DOM_ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0]     data_q;
  logic [DATA_W-1:0]     data_d;
  logic                  en_q;
  logic                  en_d;
  logic                  done_q;
  logic                  done_d;
  logic                  ovf_q;
  logic                  ovf_d;

  res_t                  in_ent;
  res_t                  head;
  logic                  full;
  logic                  empty;
  logic                  run;
  logic                  push;
  logic                  pop;
  logic                  flush;
  logic [DOM_ADDR_W-1:0] base;
  logic [DOM_ADDR_W-1:0] head_off;
  logic [DATA_W-1:0]     wdata;

  assign run      = (state_q == RUN);
  assign in_ready = run & ~full;
  assign push     = in_valid & in_ready;
  assign pop      = run & ~empty & dom_grant;
  // A written last entry ends the run; anything behind it is dropped.
  assign flush    = pop & head.last;

  assign in_ent.layer = in_layer;
  assign in_ent.last  = in_last;
  assign in_ent.data  = in_data;

  dom_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (RES_W)
  ) u_fifo (
    .clk_i   (clock),
    .rst_i   (reset),
    .flush_i (flush),
    .push_i  (push),
    .wdata_i (in_ent),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty)
  );

  always_comb begin
    base = '0;
    case (head.layer)
      2'd0:    base = DOM_ADDR_W'(LAYER0_BASE);
      2'd1:    base = DOM_ADDR_W'(LAYER1_BASE);
      2'd2:    base = DOM_ADDR_W'(LAYER2_BASE);
      default: base = DOM_ADDR_W'(LAYER3_BASE);
    endcase
  end

  assign head_off = off_q[head.layer];

`ifdef DOM_WRITER_RELU_EN
  assign wdata = relu(head.data);
`else
  assign wdata = head.data;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    en_d    = 1'b0;
    done_d  = done_q;
    ovf_d   = ovf_q;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      off_d[i] = off_q[i];
    end
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          done_d  = 1'b0;
          ovf_d   = 1'b0;
          for (int i = 0; i < NUM_LAYERS; i++) begin
            off_d[i] = '0;
          end
        end
      end
      RUN: begin
        if (pop) begin
          en_d   = 1'b1;
          addr_d = base + head_off;
          data_d = wdata;
          if (head_off == OFF_MAX) begin
            off_d[head.layer] = '0;
            ovf_d             = 1'b1;
          end else begin
            off_d[head.layer] = head_off + 1'b1;
          end
          if (head.last) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < NUM_LAYERS; i++) begin
        off_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      en_q    <= en_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      for (int i = 0; i < NUM_LAYERS; i++) begin
        off_q[i] <= off_d[i];
      end
    end
  end

  assign dom_address = addr_q;
  assign dom_data    = data_q;
  assign dom_enable  = en_q;
  assign done        = done_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_dom_writer.sv
// Bench for dom_writer: directed table, corner sequences,
// and random traffic against a queue-based reference model.
module tb_dom_writer;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [1:0]  in_layer;
  logic        in_last;
  logic        dom_grant;
  logic [9:0]  dom_address;
  logic [15:0] dom_data;
  logic        dom_enable;
  logic        done;
  logic        overflow;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  dom_writer dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_layer    (in_layer),
    .in_last     (in_last),
    .dom_grant   (dom_grant),
    .dom_address (dom_address),
    .dom_data    (dom_data),
    .dom_enable  (dom_enable),
    .done        (done),
    .overflow    (overflow)
  );

  typedef struct {
    logic [1:0]  l;
    bit          la;
    logic [15:0] d;
  } ent_t;

  // Model: pending words, run phase, per-layer word counts.
  ent_t        mq[$];
  int          ms;
  int          moff[4];
  bit          movf;
  bit          mdone;
  bit          men;
  int          maddr;
  logic [15:0] mdata;
  logic        rdy_seen;

  function automatic logic [15:0] exp_word(input logic [15:0] d);
`ifdef DOM_WRITER_RELU_EN
    return d[15] ? 16'h0000 : d;
`else
    return d;
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    ms    = 0;
    movf  = 0;
    mdone = 0;
    men   = 0;
    maddr = 0;
    mdata = 16'h0;
    for (int i = 0; i < 4; i++) moff[i] = 0;
  endtask

  function automatic bit model_ready();
    return (ms == 1) && (mq.size() < 4);
  endfunction

  task automatic model_edge(input bit v, input logic [15:0] d,
                            input logic [1:0] l, input bit la,
                            input bit g, input bit st);
    bit   rdy;
    ent_t e;
    rdy = model_ready();
    men = 0;
    if (ms == 1) begin
      if (g && mq.size() > 0) begin
        e     = mq.pop_front();
        men   = 1;
        maddr = (e.l * 64 + moff[e.l]) % 1024;
        mdata = exp_word(e.d);
        moff[e.l] = moff[e.l] + 1;
        if (moff[e.l] == 64) begin
          moff[e.l] = 0;
          movf      = 1;
        end
        if (e.la) begin
          ms    = 2;
          mdone = 1;
          mq.delete();
          rdy   = 0;
        end
      end
      if (v && rdy) begin
        e.l  = l;
        e.la = la;
        e.d  = d;
        mq.push_back(e);
      end
    end else if (st) begin
      ms   = 1;
      movf = 0;
      mdone = 0;
      for (int i = 0; i < 4; i++) moff[i] = 0;
    end
  endtask

  task automatic step(input bit v, input logic [15:0] d,
                      input logic [1:0] l, input bit la,
                      input bit g, input bit st);
    in_valid  = v;
    in_data   = d;
    in_layer  = l;
    in_last   = la;
    dom_grant = g;
    start     = st;
    #1;
    rdy_seen = in_ready;
    chk("in_ready", in_ready, model_ready());
    @(posedge clock);
    model_edge(v, d, l, la, g, st);
    #1;
    chk("dom_enable", dom_enable, men);
    chk("dom_address", dom_address, maddr);
    chk("dom_data", dom_data, mdata);
    chk("done", done, mdone);
    chk("overflow", overflow, movf);
  endtask

  typedef struct {
    bit          v;
    logic [15:0] d;
    logic [1:0]  l;
    bit          la;
    bit          g;
    bit          st;
    bit          e_rdy;
    bit          e_en;
    logic [9:0]  e_addr;
    logic [15:0] e_data;
    bit          e_done;
  } vec_t;

  vec_t tbl[9];
  int   acc;

  initial begin
    tbl[0] = '{0, 16'h0000, 2'd0, 0, 1, 1, 0, 0, 10'd0,  16'h0000, 0};
    tbl[1] = '{1, 16'h0010, 2'd0, 0, 1, 0, 1, 0, 10'd0,  16'h0000, 0};
    tbl[2] = '{0, 16'h0000, 2'd0, 0, 1, 0, 1, 1, 10'd0,  16'h0010, 0};
    tbl[3] = '{0, 16'h0000, 2'd0, 0, 1, 0, 1, 0, 10'd0,  16'h0010, 0};
    tbl[4] = '{1, 16'h0101, 2'd1, 0, 1, 0, 1, 0, 10'd0,  16'h0010, 0};
    tbl[5] = '{1, 16'h0102, 2'd1, 0, 1, 0, 1, 1, 10'd64, 16'h0101, 0};
    tbl[6] = '{1, 16'h0103, 2'd1, 1, 1, 0, 1, 1, 10'd65, 16'h0102, 0};
    tbl[7] = '{0, 16'h0000, 2'd0, 0, 1, 0, 1, 1, 10'd66, 16'h0103, 1};
    tbl[8] = '{1, 16'h5555, 2'd0, 0, 1, 0, 0, 0, 10'd66, 16'h0103, 1};

    reset     = 1'b1;
    start     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_layer  = '0;
    in_last   = 1'b0;
    dom_grant = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    chk("rst_enable", dom_enable, 0);
    chk("rst_address", dom_address, 0);
    chk("rst_data", dom_data, 0);
    chk("rst_done", done, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_ready", in_ready, 0);
    reset = 1'b0;

    // Directed table: single write latency, then a 3-word layer-1 run.
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].la, tbl[i].g, tbl[i].st);
      chk($sformatf("tbl%0d_rdy", i), rdy_seen, tbl[i].e_rdy);
      chk($sformatf("tbl%0d_en", i), dom_enable, tbl[i].e_en);
      chk($sformatf("tbl%0d_addr", i), dom_address, tbl[i].e_addr);
      chk($sformatf("tbl%0d_data", i), dom_data, tbl[i].e_data);
      chk($sformatf("tbl%0d_done", i), done, tbl[i].e_done);
    end

    // Grant stall: FIFO fills after 4 accepts, then drains in order.
    step(0, 0, 0, 0, 0, 1);
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      step(1, 16'h0200 + 16'(i), 2'd2, 0, 0, 0);
      if (rdy_seen) acc++;
    end
    chk("stall_accepts", acc, 4);
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0, 0, 1, 0);
      if (i == 3) begin
        chk("stall_last_addr", dom_address, 131);
        chk("stall_last_data", dom_data, 16'h0203);
      end
    end

    // Layer offset wrap on the 65th layer-0 word.
    for (int i = 0; i < 65; i++) begin
      step(1, 16'(i), 2'd0, 0, 1, 0);
    end
    step(0, 0, 0, 0, 1, 0);
    chk("wrap_en", dom_enable, 1);
    chk("wrap_addr", dom_address, 0);
    chk("wrap_data", dom_data, 16'd64);
    chk("wrap_ovf", overflow, 1);
    repeat (3) step(0, 0, 0, 0, 1, 0);
    chk("wrap_ovf_sticky", overflow, 1);

    // Negative result on layer 3.
    step(1, 16'hFFF0, 2'd3, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    chk("neg_addr", dom_address, 192);
`ifdef DOM_WRITER_RELU_EN
    chk("neg_data", dom_data, 16'h0000);
`else
    chk("neg_data", dom_data, 16'hFFF0);
`endif

    // Reset while two words are queued.
    step(1, 16'h1111, 2'd1, 0, 0, 0);
    step(1, 16'h2222, 2'd1, 0, 0, 0);
    reset = 1'b1;
    #1;
    chk("midrst_enable", dom_enable, 0);
    chk("midrst_address", dom_address, 0);
    chk("midrst_data", dom_data, 0);
    chk("midrst_overflow", overflow, 0);
    chk("midrst_ready", in_ready, 0);
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b0;
    repeat (3) step(1, 16'h7777, 2'd0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 1);
    step(1, 16'h3333, 2'd0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    chk("restart_addr", dom_address, 0);
    chk("restart_data", dom_data, 16'h3333);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      step(($urandom % 4) != 0, 16'($urandom), 2'($urandom),
           ($urandom % 24) == 0, ($urandom % 3) != 0,
           ($urandom % 8) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
